bitrev_reorder_ctrl: RTL and testbench

BITREV_REORDER_CTRL -- requirements
Module: bitrev_reorder_ctrl

---
 rtl/bitrev_reorder_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bitrev_reorder_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_reorder_ctrl.sv
// -----------------------------------------------------------------------------
// bitrev_reorder_ctrl
// Ping-pong reorder buffer that turns 32-sample frames from natural order into
// 5-bit bit-reversed order. The write side fills one bank while the read side
// drains the other, so with no backpressure the block moves one sample per
// cycle in each direction.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   flush      : synchronous abort; empties both banks and discards all frames
//   in_valid   : input sample present
//   in_data    : input sample, natural order (DATA_W bits)
//   in_ready   : block accepts in_data this cycle
//   out_valid  : out_data holds a valid sample
//   out_data   : output sample, bit-reversed order (DATA_W bits)
//   out_ready  : downstream takes out_data this cycle
//   out_last   : only with BITREV_LAST_EN defined; marks the 32nd output of a frame
//
// Configuration macro: BITREV_LAST_EN (adds out_last)
// -----------------------------------------------------------------------------
module bitrev_reorder_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef BITREV_LAST_EN
  ,
  output logic              out_last
`endif
);

  localparam logic BANK_EMPTY = 1'b0;
  localparam logic BANK_FULL  = 1'b1;

  // 5-bit index bit reversal
  function automatic logic [4:0] rev5(input logic [4:0] idx);
    rev5 = {idx[0], idx[1], idx[2], idx[3], idx[4]};
  endfunction

  logic [DATA_W-1:0] mem_q [2][32];

  logic [1:0]        bank_q,      bank_d;
  logic              wbank_q,     wbank_d;
  logic [4:0]        wcnt_q,      wcnt_d;
  logic              rbank_q,     rbank_d;
  logic [4:0]        rcnt_q,      rcnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  // Holds in_ready low during reset and opens it on the first edge after release.
  logic              rdy_en_q,    rdy_en_d;
`ifdef BITREV_LAST_EN
  logic              out_last_q,  out_last_d;
`endif

  logic accept_s;
  logic load_s;

  // Handshake decode from registered state only (plus the flush input).
  always_comb begin
    in_ready = rdy_en_q && (bank_q[wbank_q] == BANK_EMPTY) && !flush;
    accept_s = in_valid && in_ready;
    load_s   = (bank_q[rbank_q] == BANK_FULL) && (!out_valid_q || out_ready);
  end

  // Next-state computation for bank flags, counters and the output register.
  always_comb begin
    bank_d      = bank_q;
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    rbank_d     = rbank_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rdy_en_d    = 1'b1;
`ifdef BITREV_LAST_EN
    out_last_d  = out_last_q;
`endif
    if (flush) begin
      // flush wins over any accept or load on the same edge
      bank_d      = 2'b00;
      wbank_d     = 1'b0;
      wcnt_d      = 5'd0;
      rbank_d     = 1'b0;
      rcnt_d      = 5'd0;
      out_valid_d = 1'b0;
`ifdef BITREV_LAST_EN
      out_last_d  = 1'b0;
`endif
    end else begin
      if (accept_s) begin
        wcnt_d = wcnt_q + 5'd1;
        if (wcnt_q == 5'd31) begin
          bank_d[wbank_q] = BANK_FULL;
          wbank_d         = ~wbank_q;
        end else begin
          wbank_d = wbank_q;
        end
      end else begin
        wcnt_d = wcnt_q;
      end
      // Writer only touches an EMPTY bank and reader only a FULL one, so the
      // two flag updates never land on the same bank.
      if (load_s) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[rbank_q][rev5(rcnt_q)];
        rcnt_d      = rcnt_q + 5'd1;
`ifdef BITREV_LAST_EN
        out_last_d  = (rcnt_q == 5'd31);
`endif
        if (rcnt_q == 5'd31) begin
          bank_d[rbank_q] = BANK_EMPTY;
          rbank_d         = ~rbank_q;
        end else begin
          rbank_d = rbank_q;
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
`ifdef BITREV_LAST_EN
        out_last_d  = 1'b0;
`endif
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q      <= 2'b00;
      wbank_q     <= 1'b0;
      wcnt_q      <= 5'd0;
      rbank_q     <= 1'b0;
      rcnt_q      <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rdy_en_q    <= 1'b0;
`ifdef BITREV_LAST_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      bank_q      <= bank_d;
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rdy_en_q    <= rdy_en_d;
`ifdef BITREV_LAST_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

  // Sample storage; contents are don't-care after reset because bank flags gate use.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wbank_q][wcnt_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef BITREV_LAST_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for bitrev_reorder_ctrl. A frame-level scoreboard turns
// every 32 accepted inputs into the expected bit-reversed output sequence;
// directed sequences cover latency, throughput, backpressure, flush and reset.
// -----------------------------------------------------------------------------
module tb_bitrev_reorder_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
`ifdef BITREV_LAST_EN
  logic          out_last;
`endif

  always #5 clk = ~clk;

  bitrev_reorder_ctrl #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef BITREV_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  typedef struct {
    logic [DW-1:0] in_data;
    logic [DW-1:0] exp_out;
  } vec_t;

  vec_t          vec [32];
  int            exp_order [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                                    1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] wr_buf [$];
  logic [DW-1:0] exp_q  [$];
  int            n_out;
  int            n_acc;
  logic          hold_pending;
  logic [DW-1:0] hold_data;
  logic          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // reference bit reversal by arithmetic
  function automatic int brev(input int i);
    int r = 0;
    for (int b = 0; b < 5; b++) begin
      if (((i >> b) & 1) != 0) r += (1 << (4 - b));
    end
    return r;
  endfunction

  task automatic model_clear();
    wr_buf.delete();
    exp_q.delete();
    hold_pending = 1'b0;
  endtask

  // One clock cycle: drive inputs, score the handshakes, advance past the edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    logic take;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (hold_pending) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {16'd0, out_data}, {16'd0, hold_data});
    end
    last_acc = in_valid && in_ready;
    take     = out_valid && out_ready;
    if (take) begin
      if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else chk("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      n_out++;
    end
    hold_pending = out_valid && !out_ready;
    hold_data    = out_data;
    if (last_acc) begin
      wr_buf.push_back(d);
      n_acc++;
      if (wr_buf.size() == 32) begin
        for (int k = 0; k < 32; k++) exp_q.push_back(wr_buf[brev(k)]);
        wr_buf.delete();
      end
    end
    @(posedge clk);
    #1;
    if (fl) begin
      model_clear();
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_clear();
    n_out = 0;
    n_acc = 0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
`ifdef BITREV_LAST_EN
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Table-driven single frame: latency and exact bit-reversed order.
  task automatic t_table();
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, vec[i].in_data, 1'b1, 1'b0);
      chk("tbl_accept", {31'd0, last_acc}, 32'd1);
      chk("tbl_latency_low", {31'd0, out_valid}, 32'd0);
    end
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    for (int j = 0; j < 32; j++) begin
      chk("tbl_valid", {31'd0, out_valid}, 32'd1);
      chk("tbl_out", {16'd0, out_data}, {16'd0, vec[j].exp_out});
`ifdef BITREV_LAST_EN
      chk("tbl_last", {31'd0, out_last}, (j == 31) ? 32'd1 : 32'd0);
`endif
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
    end
    chk("tbl_end_valid", {31'd0, out_valid}, 32'd0);
    chk("tbl_sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  drops;
    int  gaps;
    int  bound;
    bit  rdy_seen;

    for (int i = 0; i < 32; i++) begin
      vec[i].in_data = 16'(i);
      vec[i].exp_out = 16'(exp_order[i]);
    end

    // reset state and single frame
    do_reset();
    t_table();

    // three back-to-back frames, no input stall, no output gap
    do_reset();
    drops = 0;
    gaps  = 0;
    for (int i = 0; i < 96; i++) begin
      cyc(1'b1, 16'(i), 1'b1, 1'b0);
      if (!last_acc) drops++;
      if (n_out > 0 && n_out < 96 && !out_valid) gaps++;
    end
    bound = 0;
    while (n_out < 96 && bound < 200) begin
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
      if (n_out > 0 && n_out < 96 && !out_valid) gaps++;
      bound++;
    end
    chk("b2b_in_ready_drops", drops, 32'd0);
    chk("b2b_out_gaps", gaps, 32'd0);
    chk("b2b_out_count", n_out, 32'd96);

    // full backpressure: both banks fill, then drain
    do_reset();
    bound = 0;
    while (n_acc < 64 && bound < 100) begin
      cyc(1'b1, 16'(n_acc), 1'b0, 1'b0);
      bound++;
    end
    chk("bp_accepts", n_acc, 32'd64);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'd64, 1'b0, 1'b0);
      chk("bp_no_accept", {31'd0, last_acc}, 32'd0);
    end
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_data0", {16'd0, out_data}, 32'd0);
    rdy_seen = 1'b0;
    bound    = 0;
    while (n_out < 64 && bound < 200) begin
      if (!rdy_seen && in_ready) begin
        rdy_seen = 1'b1;
        chk("bp_ready_return", n_out, 32'd31);
      end
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
      bound++;
    end
    chk("bp_ready_seen", {31'd0, rdy_seen}, 32'd1);
    chk("bp_out_count", n_out, 32'd64);

    // random backpressure over four frames
    do_reset();
    bound = 0;
    while (n_out < 128 && bound < 3000) begin
      cyc((n_acc < 128) ? ($urandom_range(3) != 0) : 1'b0, 16'($urandom), 1'($urandom_range(1)), 1'b0);
      bound++;
    end
    chk("rnd_out_count", n_out, 32'd128);
    chk("rnd_sb_empty", exp_q.size(), 32'd0);

    // flush while frame 1 drains and frame 2 is partial
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1'b1, 16'(200 + i), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 16'(300 + i), 1'b1, 1'b0);
      chk("fl_frame2_accept", {31'd0, last_acc}, 32'd1);
    end
    cyc(1'b0, 16'd0, 1'b1, 1'b1);
    n_out = 0;
    for (int i = 0; i < 32; i++) cyc(1'b1, 16'(100 + i), 1'b1, 1'b0);
    chk("fl_new_frame_accepts", n_acc, 32'd74);
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    chk("fl_first_out", {16'd0, out_data}, 32'd100);
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    chk("fl_second_out", {16'd0, out_data}, 32'd116);
    bound = 0;
    while (exp_q.size() > 0 && bound < 200) begin
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
      bound++;
    end
    chk("fl_sb_empty", exp_q.size(), 32'd0);
    chk("fl_out_count", n_out, 32'd32);

    // reset mid-frame, then the single-frame sequence again
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'(500 + i), 1'b1, 1'b0);
    do_reset();
    t_table();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
